axis_frame_arbiter: RTL and testbench

Frame-granular 2:1 arbiter that shares the single AXI-Stream pixel input of the CNN datapath between two image sources. The image sources are file readers or camera front-ends. Each source emits frames with tuser on the first beat and tlast on each row end. Ownership is granted only at start-of-frame and held until the configured number of rows has completed, so frames from the two sources are never interleaved. Round-robin fairness applies between frames.

---
 rtl/axis_frame_arbiter.sv | 153 +++++++++++++++
 tb/tb_axis_frame_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter
//   Frame-granular 2:1 AXI-Stream arbiter. Two image sources share one pixel
//   input of the datapath. A source wins ownership only with a start-of-frame
//   beat (tvalid && tuser) and keeps it until cfg_rows rows (tlast handshakes)
//   have passed. Ties between simultaneous SOF requests go round-robin,
//   alternating per completed frame.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   cfg_rows              rows per frame, latched at grant (0 acts as 1)
//   s0_axis_*, s1_axis_*  source streams (tvalid/tdata/tlast/tuser in, tready out)
//   m_axis_*              datapath stream (tvalid/tdata/tlast/tuser out, tready in)
//   grant                 one-hot current owner, 00 when idle
//   frame_done            one-cycle pulse after the last beat of a frame
//   err_no_sof            one-cycle pulse after a stray non-SOF beat is dropped
//   err_mid_sof           one-cycle pulse after tuser is accepted mid-frame
module axis_frame_arbiter #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int ROW_CNT_WIDTH        = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ROW_CNT_WIDTH-1:0]        cfg_rows,
    input  logic                            s0_axis_tvalid,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                            s0_axis_tlast,
    input  logic                            s0_axis_tuser,
    output logic                            s0_axis_tready,
    input  logic                            s1_axis_tvalid,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                            s1_axis_tlast,
    input  logic                            s1_axis_tuser,
    output logic                            s1_axis_tready,
    output logic                            m_axis_tvalid,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tuser,
    input  logic                            m_axis_tready,
    output logic [1:0]                      grant,
    output logic                            frame_done,
    output logic                            err_no_sof,
    output logic                            err_mid_sof
);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t                   state_q, state_d;
    logic [1:0]               grant_q, grant_d;
    logic                     ptr_q, ptr_d;        // source preferred on a tie
    logic [ROW_CNT_WIDTH-1:0] rows_l_q, rows_l_d;
    logic [ROW_CNT_WIDTH-1:0] row_cnt_q, row_cnt_d;
    logic                     first_q, first_d;    // next owner handshake is the SOF beat
    logic                     frame_done_q, frame_done_d;
    logic                     err_no_sof_q, err_no_sof_d;
    logic                     err_mid_sof_q, err_mid_sof_d;

    logic                            active;
    logic                            own1;
    logic                            own_valid, own_last, own_user;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] own_data;
    logic                            req0, req1, stray0, stray1, win1, hs;

    assign active = (state_q == S_ACTIVE);
    assign own1   = grant_q[1];
    assign req0   = s0_axis_tvalid & s0_axis_tuser;
    assign req1   = s1_axis_tvalid & s1_axis_tuser;
    assign stray0 = s0_axis_tvalid & ~s0_axis_tuser;
    assign stray1 = s1_axis_tvalid & ~s1_axis_tuser;

    always_comb begin
        own_valid = own1 ? s1_axis_tvalid : s0_axis_tvalid;
        own_data  = own1 ? s1_axis_tdata  : s0_axis_tdata;
        own_last  = own1 ? s1_axis_tlast  : s0_axis_tlast;
        own_user  = own1 ? s1_axis_tuser  : s0_axis_tuser;
    end

    // Zero-latency pass-through from the owner; sideband zeroed when no beat.
    assign m_axis_tvalid = active & own_valid;
    assign m_axis_tdata  = m_axis_tvalid ? own_data : '0;
    assign m_axis_tlast  = m_axis_tvalid & own_last;
    assign m_axis_tuser  = m_axis_tvalid & own_user;
    assign hs            = m_axis_tvalid & m_axis_tready;

    // Idle: non-SOF beats are accepted and discarded, SOF beats wait for grant.
    // Active: only the owner sees the datapath ready; the other source is held.
    assign s0_axis_tready = active ? (grant_q[0] & m_axis_tready) : stray0;
    assign s1_axis_tready = active ? (grant_q[1] & m_axis_tready) : stray1;

    assign grant       = grant_q;
    assign frame_done  = frame_done_q;
    assign err_no_sof  = err_no_sof_q;
    assign err_mid_sof = err_mid_sof_q;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        ptr_d         = ptr_q;
        rows_l_d      = rows_l_q;
        row_cnt_d     = row_cnt_q;
        first_d       = first_q;
        frame_done_d  = 1'b0;
        err_no_sof_d  = 1'b0;
        err_mid_sof_d = 1'b0;
        win1          = (req0 & req1) ? ptr_q : req1;
        if (!active) begin
            err_no_sof_d = stray0 | stray1;
            if (req0 | req1) begin
                state_d   = S_ACTIVE;
                grant_d   = win1 ? 2'b10 : 2'b01;
                rows_l_d  = (cfg_rows == '0) ? ROW_CNT_WIDTH'(1) : cfg_rows;
                row_cnt_d = '0;
                first_d   = 1'b1;
            end
        end else if (hs) begin
            first_d       = 1'b0;
            err_mid_sof_d = own_user & ~first_q;
            if (own_last) begin
                row_cnt_d = row_cnt_q + ROW_CNT_WIDTH'(1);
                if (row_cnt_q == rows_l_q - ROW_CNT_WIDTH'(1)) begin
                    state_d      = S_IDLE;
                    grant_d      = 2'b00;
                    frame_done_d = 1'b1;
                    ptr_d        = ~own1;   // other source wins the next tie
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            grant_q       <= 2'b00;
            ptr_q         <= 1'b0;
            rows_l_q      <= ROW_CNT_WIDTH'(1);
            row_cnt_q     <= '0;
            first_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            err_no_sof_q  <= 1'b0;
            err_mid_sof_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            ptr_q         <= ptr_d;
            rows_l_q      <= rows_l_d;
            row_cnt_q     <= row_cnt_d;
            first_q       <= first_d;
            frame_done_q  <= frame_done_d;
            err_no_sof_q  <= err_no_sof_d;
            err_mid_sof_q <= err_mid_sof_d;
        end
    end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Bench for axis_frame_arbiter: idle arbitration vector table, directed frame
// sequences and randomized traffic checked cycle by cycle against a reference
// model that tracks owner, round-robin preference and rows from the rules.
module tb_axis_frame_arbiter;

    localparam int DW = 32;
    localparam int RW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
    } beat_t;

    typedef struct {
        logic       v0, u0, v1, u1;
        logic       r0, r1;
        logic [1:0] g;
        logic       ens;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [RW-1:0]        cfg = '0;
    logic [1:0]           tv = '0, tl = '0, tu = '0;
    logic [1:0][DW-1:0]   td = '0;
    wire  [1:0]           tr;
    logic                 mtr = 1'b1;
    logic                 m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic [DW-1:0]        m_axis_tdata;
    logic [1:0]           grant;
    logic                 frame_done, err_no_sof, err_mid_sof;

    axis_frame_arbiter #(.C_S_AXIS_TDATA_WIDTH(DW), .ROW_CNT_WIDTH(RW)) dut (
        .clk(clk), .reset(rst), .cfg_rows(cfg),
        .s0_axis_tvalid(tv[0]), .s0_axis_tdata(td[0]), .s0_axis_tlast(tl[0]),
        .s0_axis_tuser(tu[0]), .s0_axis_tready(tr[0]),
        .s1_axis_tvalid(tv[1]), .s1_axis_tdata(td[1]), .s1_axis_tlast(tl[1]),
        .s1_axis_tuser(tu[1]), .s1_axis_tready(tr[1]),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_tready(mtr), .grant(grant), .frame_done(frame_done),
        .err_no_sof(err_no_sof), .err_mid_sof(err_mid_sof)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- source drivers ----------------
    beat_t      drv_q[2][$];
    beat_t      exp_q[2][$];
    logic [1:0] vld = '0;
    logic [1:0] hs_seen = '0;
    int         gap_pct = 0;
    bit         bp = 1'b0;

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            tv[i] = vld[i];
            td[i] = vld[i] ? drv_q[i][0].data : '0;
            tl[i] = vld[i] ? drv_q[i][0].last : 1'b0;
            tu[i] = vld[i] ? drv_q[i][0].user : 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (hs_seen[i] && vld[i]) begin
                void'(drv_q[i].pop_front());
                vld[i] = 1'b0;
            end
            if (!vld[i] && drv_q[i].size() > 0 && int'($urandom_range(99)) >= gap_pct)
                vld[i] = 1'b1;
        end
        mtr = bp ? 1'($urandom_range(1)) : 1'b1;
        drive();
    endtask

    task automatic push_frame(input int s, input int rows, input int bpr, input int mid = -1);
        beat_t b;
        for (int k = 0; k < rows * bpr; k++) begin
            b.data = $urandom;
            b.user = (k == 0) || (k == mid);
            b.last = (k % bpr) == bpr - 1;
            drv_q[s].push_back(b);
            exp_q[s].push_back(b);
        end
    endtask

    // ---------------- reference model + monitor ----------------
    int         m_owner = -1;   // -1 idle, else owning source
    int         m_rr = 0;       // source preferred on a tie
    int         m_rows_l = 1, m_rows_done = 0;
    bit         m_first = 1'b0, fd_e = 1'b0, ens_e = 1'b0, ems_e = 1'b0;
    bit         mon_en = 1'b0;
    int         fd_cnt = 0, ens_cnt = 0, ems_cnt = 0;
    logic [1:0] glog[$];
    logic [1:0] prev_grant = '0;

    always @(negedge clk) begin : monitor
        int o;
        bit nfd, nens, nems, r0, r1;
        logic [1:0] g_e;
        beat_t e;
        hs_seen = {tv[1] & tr[1], tv[0] & tr[0]};
        o    = m_owner;
        g_e  = (o < 0) ? 2'b00 : ((o == 0) ? 2'b01 : 2'b10);
        nfd  = 1'b0;
        nens = 1'b0;
        nems = 1'b0;
        if (mon_en) begin
            chk("grant", 32'(grant), 32'(g_e));
            chk("frame_done", 32'(frame_done), 32'(fd_e));
            chk("err_no_sof", 32'(err_no_sof), 32'(ens_e));
            chk("err_mid_sof", 32'(err_mid_sof), 32'(ems_e));
            if (o < 0) begin
                chk("idle_m_tvalid", 32'(m_axis_tvalid), 0);
                chk("idle_tready0", 32'(tr[0]), 32'(tv[0] & ~tu[0]));
                chk("idle_tready1", 32'(tr[1]), 32'(tv[1] & ~tu[1]));
            end else begin
                chk("fwd_tvalid", 32'(m_axis_tvalid), 32'(tv[o]));
                chk("owner_tready", 32'(tr[o]), 32'(mtr));
                chk("other_tready", 32'(tr[1-o]), 0);
                chk("fwd_tdata", m_axis_tdata, tv[o] ? td[o] : 32'h0);
                chk("fwd_tlast", 32'(m_axis_tlast), 32'(tv[o] & tl[o]));
                chk("fwd_tuser", 32'(m_axis_tuser), 32'(tv[o] & tu[o]));
                if (tv[o] && mtr) begin
                    chk("sb_has_beat", 32'(exp_q[o].size() > 0), 1);
                    if (exp_q[o].size() > 0) begin
                        e = exp_q[o].pop_front();
                        chk("sb_data", m_axis_tdata, e.data);
                        chk("sb_last", 32'(m_axis_tlast), 32'(e.last));
                        chk("sb_user", 32'(m_axis_tuser), 32'(e.user));
                    end
                end
            end
            if (frame_done)  fd_cnt++;
            if (err_no_sof)  ens_cnt++;
            if (err_mid_sof) ems_cnt++;
            if (grant != 2'b00 && prev_grant == 2'b00) glog.push_back(grant);
        end
        prev_grant = grant;
        if (rst) begin
            m_owner = -1;
            m_rr    = 0;
        end else if (o < 0) begin
            r0   = tv[0] & tu[0];
            r1   = tv[1] & tu[1];
            nens = (tv[0] & ~tu[0]) | (tv[1] & ~tu[1]);
            if (r0 || r1) begin
                m_owner     = (r0 && r1) ? m_rr : (r0 ? 0 : 1);
                m_rows_l    = (cfg == 0) ? 1 : int'(cfg);
                m_rows_done = 0;
                m_first     = 1'b1;
            end
        end else if (tv[o] && mtr) begin
            nems    = tu[o] & ~m_first;
            m_first = 1'b0;
            if (tl[o]) begin
                m_rows_done++;
                if (m_rows_done == m_rows_l) begin
                    nfd     = 1'b1;
                    m_rr    = 1 - o;
                    m_owner = -1;
                end
            end
        end
        fd_e  = nfd;
        ens_e = nens;
        ems_e = nems;
    end

    task automatic do_reset();
        vld = '0;
        for (int i = 0; i < 2; i++) begin
            drv_q[i].delete();
            exp_q[i].delete();
        end
        drive();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_cnt();
        fd_cnt = 0; ens_cnt = 0; ems_cnt = 0;
        glog.delete();
    endtask

    task automatic run_idle(input int max);
        int n = 0;
        while ((drv_q[0].size() > 0 || drv_q[1].size() > 0 || m_owner >= 0) && n < max) begin
            tick();
            n++;
        end
        chk("run_within_budget", 32'(n < max), 1);
        tick();
        tick();
        chk("sb_drained0", 32'(exp_q[0].size()), 0);
        chk("sb_drained1", 32'(exp_q[1].size()), 0);
    endtask

    task automatic chk_glog(input string name, input int idx, input logic [1:0] exp);
        chk(name, (glog.size() > idx) ? 32'(glog[idx]) : 32'hFFFF, 32'(exp));
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        vec_t vt[9];
        int   n;
        vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
        vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1};
        vt[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0};
        vt[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0};
        vt[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0};
        vt[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1};
        vt[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1};
        vt[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
        vt[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1};

        // reset state
        cfg = 16'd1;
        do_reset();
        @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_err_no_sof", 32'(err_no_sof), 0);
        chk("rst_err_mid_sof", 32'(err_mid_sof), 0);
        chk("rst_m_tvalid", 32'(m_axis_tvalid), 0);
        chk("rst_m_tdata", m_axis_tdata, 0);
        chk("rst_tready", 32'(tr), 0);

        // idle arbitration table, each vector straight out of reset
        for (int k = 0; k < 9; k++) begin
            do_reset();
            tv = {vt[k].v1, vt[k].v0};
            tu = {vt[k].u1, vt[k].u0};
            tl = '0;
            td[0] = 32'h100 + k;
            td[1] = 32'h200 + k;
            mtr = 1'b0;
            @(negedge clk);
            chk("vec_tready0", 32'(tr[0]), 32'(vt[k].r0));
            chk("vec_tready1", 32'(tr[1]), 32'(vt[k].r1));
            chk("vec_m_tvalid", 32'(m_axis_tvalid), 0);
            tick();
            @(negedge clk);
            chk("vec_grant", 32'(grant), 32'(vt[k].g));
            chk("vec_err_no_sof", 32'(err_no_sof), 32'(vt[k].ens));
        end

        do_reset();
        mon_en = 1'b1;

        // single frame, 3 rows x 4 beats; cfg_rows changed mid-frame is ignored
        clear_cnt();
        cfg = 16'd3;
        push_frame(0, 3, 4);
        n = 0;
        while (m_owner != 0 && n < 50) begin tick(); n++; end
        chk("t1_granted", 32'(n < 50), 1);
        cfg = 16'd7;
        run_idle(200);
        chk("t1_frames", 32'(fd_cnt), 1);
        chk_glog("t1_grant", 0, 2'b01);

        // simultaneous requests after reset, 3 frames each
        do_reset();
        clear_cnt();
        cfg = 16'd2;
        for (int f = 0; f < 3; f++) begin
            push_frame(0, 2, 2);
            push_frame(1, 2, 2);
        end
        run_idle(400);
        chk("t2_frames", 32'(fd_cnt), 6);
        for (int k = 0; k < 6; k++) chk_glog("t2_grant_seq", k, (k % 2) ? 2'b10 : 2'b01);

        // backpressure: s1 waits behind s0 under random m_axis_tready
        clear_cnt();
        bp = 1'b1;
        push_frame(0, 2, 3);
        n = 0;
        while (m_owner != 0 && n < 50) begin tick(); n++; end
        chk("t3_granted", 32'(n < 50), 1);
        push_frame(1, 2, 3);
        run_idle(400);
        bp = 1'b0;
        chk("t3_frames", 32'(fd_cnt), 2);
        chk_glog("t3_first", 0, 2'b01);
        chk_glog("t3_second", 1, 2'b10);

        // stray beat from s1 while idle, then a real frame from s1
        clear_cnt();
        cfg = 16'd1;
        drv_q[1].push_back('{data: 32'hA5, last: 1'b0, user: 1'b0});
        push_frame(1, 1, 3);
        run_idle(100);
        chk("t4_err_no_sof_cnt", 32'(ens_cnt), 1);
        chk("t4_frames", 32'(fd_cnt), 1);
        chk_glog("t4_grant", 0, 2'b10);

        // mid-frame SOF on beat 3 of a 2-row frame from s0
        clear_cnt();
        cfg = 16'd2;
        push_frame(0, 2, 2, 2);
        run_idle(100);
        chk("t5_err_mid_sof_cnt", 32'(ems_cnt), 1);
        chk("t5_frames", 32'(fd_cnt), 1);

        // reset after 5 of 12 beats from s1; pointer returns to s0
        clear_cnt();
        cfg = 16'd3;
        push_frame(1, 3, 4);
        n = 0;
        while (drv_q[1].size() > 7 && n < 100) begin tick(); n++; end
        chk("t6_five_beats", 32'(drv_q[1].size()), 7);
        rst = 1'b1;
        vld[1] = 1'b0;
        drv_q[1].delete();
        exp_q[1].delete();
        drive();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_grant_after_rst", 32'(grant), 0);
        chk("t6_m_tvalid_after_rst", 32'(m_axis_tvalid), 0);
        clear_cnt();
        cfg = 16'd1;
        push_frame(0, 1, 2);
        push_frame(1, 1, 2);
        run_idle(100);
        chk_glog("t6_first_s0", 0, 2'b01);
        chk_glog("t6_then_s1", 1, 2'b10);

        // randomized traffic with valid gaps and backpressure
        gap_pct = 30;
        bp = 1'b1;
        for (int r = 0; r < 6; r++) begin
            int rows;
            clear_cnt();
            cfg  = (r == 0) ? 16'd0 : 16'($urandom_range(4, 1));
            rows = (cfg == 0) ? 1 : int'(cfg);
            for (int f = 0; f < 3; f++) begin
                push_frame(0, rows, int'($urandom_range(3, 1)));
                push_frame(1, rows, int'($urandom_range(3, 1)));
            end
            run_idle(5000);
            chk("rand_frames", 32'(fd_cnt), 6);
            chk("rand_no_errors", 32'(ens_cnt + ems_cnt), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
